truth_table_sweeper: RTL and testbench
======================================

# truth_table_sweeper

Sequential stimulus-and-capture stage for the combinational lab circuits. On a start pulse it walks an N-input combinational DUT through every input vector in ascending binary order and holds each vector for a programmable number of settle cycles. It samples the DUT's single output into a packed truth-table register and compares it bit-for-bit against an expected table. It sits directly upstream of the DUT (drives its inputs) and captures the DUT's output, replacing hand-written `#1` stimulus sequences with a clocked, self-checking sweep.

## Interface
- N_IN, default 3: number of DUT inputs, legal 1..4; table width is 2**N_IN.
- HOLD, default 1: cycles each vector is held before sampling, legal 1..15.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level sampled in IDLE; begins a sweep.
- expected  in  2**N_IN  expected output; bit k is the response to vector k; latched at start.
- dut_y  in  1  DUT output.
- vec  out  N_IN  vector driven to DUT inputs; MSB = first listed input (A).
- busy  out  1  high while sweeping.
- done  out  1  one-cycle pulse when the last vector is sampled.
- pass  out  1  high after a sweep with zero mismatches; held until next start.
- table  out  2**N_IN  captured outputs; bit k = dut_y sampled for vector k.
- err_count  out  N_IN+1  number of mismatching vectors.
- first_err  out  N_IN  lowest mismatching vector.
- first_err_valid  out  1  at least one mismatch recorded.

## Operation
- Reset (async, immediate): state IDLE; vec, busy, done, pass, table, err_count, first_err, first_err_valid = 0; hold counter = 0; latched expected = 0.
- States: IDLE, RUN.
- IDLE: on an edge with start=1, latch expected; clear table, err_count, pass, first_err, first_err_valid; set vec=0, hold_cnt=0, busy=1; go to RUN.
- RUN, each edge: if hold_cnt < HOLD-1, increment hold_cnt. Otherwise sample:
  - table[vec] <= dut_y.
  - If dut_y != expected_latched[vec]: err_count+1. If first_err_valid=0, set first_err=vec and first_err_valid=1.
  - If vec == 2**N_IN-1: busy=0, done=1, pass = (no mismatch in the whole sweep, including this sample); go to IDLE; vec holds its final value.
  - Else: vec+1, hold_cnt=0.
- done is high only on the cycle following the final sample edge.
- Results (table, err_count, first_err*, pass) hold in IDLE until the next accepted start.
- start while busy=1 is ignored. No restart or abort except rst.
- expected changes during RUN have no effect.
- err_count is N_IN+1 bits wide, so it cannot wrap; maximum is 2**N_IN.

## Timing
- Let E0 be the edge accepting start.
- busy rises at E0.
- Vector k is presented from E0 + k·HOLD and is sampled at edge E0 + (k+1)·HOLD.
- done pulses high at E0 + 2**N_IN·HOLD; busy falls on the same edge.
- A new start is accepted no earlier than E0 + 2**N_IN·HOLD + 1, i.e. start may be asserted while done=1.
- The DUT is combinational, so dut_y must settle within HOLD cycles of the vec change. HOLD=1 samples a full cycle after vec updates.
- rst asserted mid-sweep forces all outputs to their reset values immediately. After release, the next start behaves identically to the first after power-up.

## Test plan
- Reset: hold rst with start=1. All outputs 0 and start ignored. Release rst; no activity until start.
- N_IN=3, HOLD=1, DUT y=A&B&C, expected=8'h80, start at E0:
  - vec steps 0..7 once per cycle.
  - done at E0+8, table=8'h80, err_count=0, pass=1, first_err_valid=0.
- N_IN=3, HOLD=1, DUT y=A|B|C, expected=8'h80:
  - table=8'hFE, err_count=6, first_err=3'd1, first_err_valid=1, pass=0.
- N_IN=4, HOLD=3, DUT with 1-cycle registered output of XOR of inputs, expected=16'h6996:
  - vec changes every 3 cycles, done at E0+48, pass=1.
- Pulse start again while busy at vec=2: sweep unaffected, one done only. Assert start on the done cycle: second sweep starts on the next edge, with results cleared.
- Assert rst when vec=3 mid-sweep: outputs zero at once. A new start after release yields a full, correct sweep (pass=1 for the AND3 case).

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Clocked stimulus-and-capture stage: sweeps every N_IN-bit vector into a combinational
// DUT, samples its output into a truth table and scores it against an expected table.
// The captured-table port is named truth_table because `table` is a reserved word.
module truth_table_sweeper #(
  parameter int N_IN = 3,
  parameter int HOLD = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   expected,
  input  logic                   dut_y,
  output logic [N_IN-1:0]        vec,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [(1<<N_IN)-1:0]   truth_table,
  output logic [N_IN:0]          err_count,
  output logic [N_IN-1:0]        first_err,
  output logic                   first_err_valid
);

  localparam int              TW        = 1 << N_IN;
  localparam logic [3:0]      HOLD_LAST = 4'(HOLD - 1);
  localparam logic [N_IN-1:0] VEC_ONE   = 1;
  localparam logic [N_IN:0]   ERR_ONE   = 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_next;
  logic [3:0]      hold_cnt;
  logic [TW-1:0]   exp_q;
  logic            sample;
  logic            mismatch;
  logic            last_vec;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sample     = (state == RUN) && (hold_cnt == HOLD_LAST);
    mismatch   = (dut_y != exp_q[vec]);
    last_vec   = (vec == {N_IN{1'b1}});
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (sample && last_vec) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: the latched expected table is a plain register, so it is reset along with the results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec             <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      truth_table     <= '0;
      err_count       <= '0;
      first_err       <= '0;
      first_err_valid <= 1'b0;
      hold_cnt        <= '0;
      exp_q           <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            exp_q           <= expected;
            truth_table     <= '0;
            err_count       <= '0;
            pass            <= 1'b0;
            first_err       <= '0;
            first_err_valid <= 1'b0;
            vec             <= '0;
            hold_cnt        <= '0;
            busy            <= 1'b1;
          end
        end
        RUN: begin
          if (!sample) begin
            hold_cnt <= hold_cnt + 4'd1;
          end else begin
            truth_table[vec] <= dut_y;
            if (mismatch) begin
              err_count <= err_count + ERR_ONE;
              if (!first_err_valid) begin
                first_err       <= vec;
                first_err_valid <= 1'b1;
              end
            end
            // Final vector: vec stays put so it shows the last vector driven.
            if (last_vec) begin
              busy <= 1'b0;
              done <= 1'b1;
              pass <= !first_err_valid && !mismatch;
            end else begin
              vec      <= vec + VEC_ONE;
              hold_cnt <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: a 3-input/HOLD=1 instance driving AND3/OR3
// and a 4-input/HOLD=3 instance driving a registered XOR4.
module tb_truth_table_sweeper;

  typedef struct packed {
    logic [15:0] tbl;
    logic [4:0]  errs;
    logic [3:0]  first;
    logic        fev;
    logic        pass;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // 3-input instance
  logic       start3, mode3, y3, busy3, done3, pass3, fev3;
  logic [7:0] exp3, tbl3;
  logic [2:0] vec3, first3;
  logic [3:0] errs3;
  assign y3 = mode3 ? (|vec3) : (&vec3);

  truth_table_sweeper #(.N_IN(3), .HOLD(1)) u3 (
    .clk(clk), .rst(rst), .start(start3), .expected(exp3), .dut_y(y3),
    .vec(vec3), .busy(busy3), .done(done3), .pass(pass3), .truth_table(tbl3),
    .err_count(errs3), .first_err(first3), .first_err_valid(fev3)
  );

  // 4-input instance with a one-cycle registered XOR as the DUT
  logic        start4, y4, busy4, done4, pass4, fev4;
  logic [15:0] exp4, tbl4;
  logic [3:0]  vec4, first4;
  logic [4:0]  errs4;
  always_ff @(posedge clk) y4 <= ^vec4;

  truth_table_sweeper #(.N_IN(4), .HOLD(3)) u4 (
    .clk(clk), .rst(rst), .start(start4), .expected(exp4), .dut_y(y4),
    .vec(vec4), .busy(busy4), .done(done4), .pass(pass4), .truth_table(tbl4),
    .err_count(errs4), .first_err(first4), .first_err_valid(fev4)
  );

  res_t q3[$];
  res_t q4[$];
  int   done3_cnt = 0;
  int   done4_cnt = 0;

  function automatic res_t model3(input bit m, input logic [7:0] e);
    res_t r;
    bit   y;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      y = m ? (k != 0) : (k == 7);
      r.tbl[k] = y;
      if (y != e[k]) begin
        r.errs = r.errs + 5'd1;
        if (!r.fev) begin
          r.first = 4'(k);
          r.fev   = 1'b1;
        end
      end
    end
    r.pass = (r.errs == 0);
    return r;
  endfunction

  function automatic res_t model4(input logic [15:0] e);
    res_t       r;
    logic [3:0] kv;
    bit         y;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      kv = 4'(k);
      y  = ^kv;
      r.tbl[k] = y;
      if (y != e[k]) begin
        r.errs = r.errs + 5'd1;
        if (!r.fev) begin
          r.first = kv;
          r.fev   = 1'b1;
        end
      end
    end
    r.pass = (r.errs == 0);
    return r;
  endfunction

  res_t r3, r4;
  always @(negedge clk) begin
    if (done3) begin
      done3_cnt++;
      if (q3.size() == 0) check("done3_unexpected", 1, 0);
      else begin
        r3 = q3.pop_front();
        check("tbl3", tbl3, r3.tbl);
        check("errs3", errs3, r3.errs);
        check("fev3", fev3, r3.fev);
        if (r3.fev) check("first3", first3, r3.first);
        check("pass3", pass3, r3.pass);
      end
    end
    if (done4) begin
      done4_cnt++;
      if (q4.size() == 0) check("done4_unexpected", 1, 0);
      else begin
        r4 = q4.pop_front();
        check("tbl4", tbl4, r4.tbl);
        check("errs4", errs4, r4.errs);
        check("fev4", fev4, r4.fev);
        if (r4.fev) check("first4", first4, r4.first);
        check("pass4", pass4, r4.pass);
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_vec3"}, vec3, 0);
    check({tag, "_busy3"}, busy3, 0);
    check({tag, "_done3"}, done3, 0);
    check({tag, "_pass3"}, pass3, 0);
    check({tag, "_tbl3"}, tbl3, 0);
    check({tag, "_errs3"}, errs3, 0);
    check({tag, "_first3"}, first3, 0);
    check({tag, "_fev3"}, fev3, 0);
    check({tag, "_vec4"}, vec4, 0);
    check({tag, "_busy4"}, busy4, 0);
    check({tag, "_done4"}, done4, 0);
    check({tag, "_tbl4"}, tbl4, 0);
    check({tag, "_errs4"}, errs4, 0);
  endtask

  // One 3-input sweep. poke pulses start while vec=2; chain leaves the task on the done
  // cycle so the caller can assert start there; abort_at >= 0 resets mid-sweep.
  task automatic sweep3(input bit m, input logic [7:0] e, input bit poke, input bit chain,
                        input int abort_at);
    mode3 = m;
    exp3  = e;
    if (abort_at < 0) q3.push_back(model3(m, e));
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    exp3   = ~e;
    check("e0_vec3", vec3, 0);
    check("e0_busy3", busy3, 1);
    check("e0_tbl3_clr", tbl3, 0);
    check("e0_errs3_clr", errs3, 0);
    check("e0_fev3_clr", fev3, 0);
    check("e0_pass3_clr", pass3, 0);
    for (int k = 1; k < 8; k++) begin
      @(posedge clk); #1;
      check("step_vec3", vec3, k);
      check("step_busy3", busy3, 1);
      check("step_done3", done3, 0);
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        check_reset("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      if (poke && k == 2) start3 = 1'b1;
      if (poke && k == 3) start3 = 1'b0;
    end
    @(posedge clk); #1;
    check("end_done3", done3, 1);
    check("end_busy3", busy3, 0);
    check("end_vec3", vec3, 7);
    if (!chain) begin
      @(posedge clk); #1;
      check("post_done3", done3, 0);
      check("post_busy3", busy3, 0);
    end
  endtask

  task automatic sweep4(input logic [15:0] e);
    exp4 = e;
    q4.push_back(model4(e));
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    check("e0_vec4", vec4, 0);
    check("e0_busy4", busy4, 1);
    for (int c = 1; c < 48; c++) begin
      @(posedge clk); #1;
      check("step_vec4", vec4, c / 3);
      check("step_done4", done4, 0);
    end
    @(posedge clk); #1;
    check("end_done4", done4, 1);
    check("end_busy4", busy4, 0);
    @(posedge clk); #1;
    check("post_done4", done4, 0);
  endtask

  initial begin
    rst    = 1'b1;
    start3 = 1'b1;
    start4 = 1'b1;
    mode3  = 1'b0;
    exp3   = 8'hFF;
    exp4   = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    start3 = 1'b0;
    start4 = 1'b0;
    rst    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("idle");

    sweep3(1'b0, 8'h80, 1'b0, 1'b0, -1);
    sweep3(1'b1, 8'h80, 1'b0, 1'b0, -1);
    sweep3(1'b0, 8'h80, 1'b1, 1'b0, -1);
    sweep3(1'b1, 8'h80, 1'b0, 1'b1, -1);
    sweep3(1'b0, 8'h80, 1'b0, 1'b0, -1);
    sweep3(1'b0, 8'h80, 1'b0, 1'b0, 3);
    repeat (2) @(posedge clk);
    #1;
    check_reset("post_rst");
    sweep3(1'b0, 8'h80, 1'b0, 1'b0, -1);

    sweep4(16'h6996);

    repeat (2) @(posedge clk);
    #1;
    check("sb3_drain", q3.size(), 0);
    check("sb4_drain", q4.size(), 0);
    check("done3_total", done3_cnt, 6);
    check("done4_total", done4_cnt, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
